// File: rtl/fft8_stream.sv
// fft8_stream: fully pipelined 8-point radix-2 DIF FFT/IFFT, one frame per clock.
// Three register stages under one stall enable; mode, tag and overflow ride with each frame.
module fft8_stream #(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16,
    parameter int TAG_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re [0:7],
    input  logic signed [WIDTH-1:0] in_im [0:7],
    input  logic                    in_inv,
    input  logic                    in_scale,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_re [0:7],
    output logic signed [WIDTH-1:0] out_im [0:7],
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_ovf
);

    // round(sqrt(2^(2*tw-3))) == round(2^(tw-1)/sqrt(2))
    function automatic longint c_calc(input int tw);
        longint x, r, t;
        x = longint'(1) << (2 * tw - 3);
        r = 0;
        for (int b = 30; b >= 0; b--) begin
            t = r + (longint'(1) << b);
            if (t * t <= x) r = t;
        end
        if (x - r * r > r) r = r + 1;
        return r;
    endfunction

    function automatic int br3(input int x);
        return ((x & 1) << 2) | (x & 2) | ((x >> 2) & 1);
    endfunction

    localparam int PW = WIDTH + TW_WIDTH + 4;
    typedef logic signed [PW-1:0] wide_t;

    localparam wide_t MAXV = wide_t'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam wide_t MINV = ~MAXV;
    localparam wide_t RND  = wide_t'(64'sd1 <<< (TW_WIDTH - 2));
    localparam wide_t CW   = wide_t'(c_calc(TW_WIDTH));

    // returns {clipped, value}
    function automatic logic [WIDTH:0] post(input wide_t v, input logic sc);
        wide_t t;
        t = sc ? (v + wide_t'(1)) >>> 1 : v;
        if (t > MAXV) return {1'b1, MAXV[WIDTH-1:0]};
        if (t < MINV) return {1'b1, MINV[WIDTH-1:0]};
        return {1'b0, t[WIDTH-1:0]};
    endfunction

    function automatic wide_t rnd(input wide_t p);
        return (p + RND) >>> (TW_WIDTH - 1);
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic signed [WIDTH-1:0] n1_re [0:7];
    logic signed [WIDTH-1:0] n1_im [0:7];
    logic signed [WIDTH-1:0] n2_re [0:7];
    logic signed [WIDTH-1:0] n2_im [0:7];
    logic signed [WIDTH-1:0] n3_re [0:7];
    logic signed [WIDTH-1:0] n3_im [0:7];
    logic signed [WIDTH-1:0] s1_re [0:7];
    logic signed [WIDTH-1:0] s1_im [0:7];
    logic signed [WIDTH-1:0] s2_re [0:7];
    logic signed [WIDTH-1:0] s2_im [0:7];
    logic [3:0] ov1, ov2, ov3;

    logic             s1_v, s1_inv, s1_sc, s1_ovf;
    logic             s2_v, s2_sc, s2_ovf;
    logic [TAG_W-1:0] s1_tag, s2_tag;

    for (genvar n = 0; n < 4; n++) begin : g_s1
        wide_t ar, ai, br, bi, dr, di, tr, ti;
        logic [WIDTH:0] q0, q1, q2, q3;
        assign ar = wide_t'(in_re[n]);
        assign ai = wide_t'(in_im[n]);
        assign br = wide_t'(in_re[n+4]);
        assign bi = wide_t'(in_im[n+4]);
        assign dr = ar - br;
        assign di = ai - bi;
        if (n == 0) begin : g_w0
            assign tr = dr;
            assign ti = di;
        end else if (n == 2) begin : g_w2
            assign tr = in_inv ? -di : di;
            assign ti = in_inv ? dr : -dr;
        end else begin : g_wm
            wide_t wr, wi;
            assign wr = (n == 1) ? CW : -CW;
            assign wi = in_inv ? CW : -CW;
            assign tr = rnd(dr * wr - di * wi);
            assign ti = rnd(dr * wi + di * wr);
        end
        assign q0 = post(ar + br, in_scale);
        assign q1 = post(ai + bi, in_scale);
        assign q2 = post(tr, in_scale);
        assign q3 = post(ti, in_scale);
        assign n1_re[n]   = q0[WIDTH-1:0];
        assign n1_im[n]   = q1[WIDTH-1:0];
        assign n1_re[n+4] = q2[WIDTH-1:0];
        assign n1_im[n+4] = q3[WIDTH-1:0];
        assign ov1[n] = q0[WIDTH] | q1[WIDTH] | q2[WIDTH] | q3[WIDTH];
    end

    for (genvar h = 0; h < 2; h++) begin : g_s2h
        for (genvar m = 0; m < 2; m++) begin : g_s2
            localparam int A = 4 * h + m;
            localparam int B = A + 2;
            wide_t ar, ai, br, bi, dr, di, tr, ti;
            logic [WIDTH:0] q0, q1, q2, q3;
            assign ar = wide_t'(s1_re[A]);
            assign ai = wide_t'(s1_im[A]);
            assign br = wide_t'(s1_re[B]);
            assign bi = wide_t'(s1_im[B]);
            assign dr = ar - br;
            assign di = ai - bi;
            if (m == 0) begin : g_w0
                assign tr = dr;
                assign ti = di;
            end else begin : g_wj
                assign tr = s1_inv ? -di : di;
                assign ti = s1_inv ? dr : -dr;
            end
            assign q0 = post(ar + br, s1_sc);
            assign q1 = post(ai + bi, s1_sc);
            assign q2 = post(tr, s1_sc);
            assign q3 = post(ti, s1_sc);
            assign n2_re[A] = q0[WIDTH-1:0];
            assign n2_im[A] = q1[WIDTH-1:0];
            assign n2_re[B] = q2[WIDTH-1:0];
            assign n2_im[B] = q3[WIDTH-1:0];
            assign ov2[2*h+m] = q0[WIDTH] | q1[WIDTH] | q2[WIDTH] | q3[WIDTH];
        end
    end

    // last butterflies land in bit-reversed slots; write them back in natural order
    for (genvar i = 0; i < 4; i++) begin : g_s3
        localparam int RA = br3(2 * i);
        localparam int RB = br3(2 * i + 1);
        wide_t ar, ai, br, bi;
        logic [WIDTH:0] q0, q1, q2, q3;
        assign ar = wide_t'(s2_re[2*i]);
        assign ai = wide_t'(s2_im[2*i]);
        assign br = wide_t'(s2_re[2*i+1]);
        assign bi = wide_t'(s2_im[2*i+1]);
        assign q0 = post(ar + br, s2_sc);
        assign q1 = post(ai + bi, s2_sc);
        assign q2 = post(ar - br, s2_sc);
        assign q3 = post(ai - bi, s2_sc);
        assign n3_re[RA] = q0[WIDTH-1:0];
        assign n3_im[RA] = q1[WIDTH-1:0];
        assign n3_re[RB] = q2[WIDTH-1:0];
        assign n3_im[RB] = q3[WIDTH-1:0];
        assign ov3[i] = q0[WIDTH] | q1[WIDTH] | q2[WIDTH] | q3[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_inv    <= 1'b0;
            s1_sc     <= 1'b0;
            s1_ovf    <= 1'b0;
            s1_tag    <= '0;
            s2_v      <= 1'b0;
            s2_sc     <= 1'b0;
            s2_ovf    <= 1'b0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
            out_tag   <= '0;
            for (int k = 0; k < 8; k++) begin
                s1_re[k]  <= '0;
                s1_im[k]  <= '0;
                s2_re[k]  <= '0;
                s2_im[k]  <= '0;
                out_re[k] <= '0;
                out_im[k] <= '0;
            end
        end else if (en) begin
            s1_v      <= in_valid;
            s1_inv    <= in_inv;
            s1_sc     <= in_scale;
            s1_tag    <= in_tag;
            s1_ovf    <= in_valid && (|ov1);
            s2_v      <= s1_v;
            s2_sc     <= s1_sc;
            s2_tag    <= s1_tag;
            s2_ovf    <= s1_ovf || (s1_v && (|ov2));
            out_valid <= s2_v;
            out_tag   <= s2_tag;
            out_ovf   <= s2_ovf || (s2_v && (|ov3));
            for (int k = 0; k < 8; k++) begin
                s1_re[k]  <= n1_re[k];
                s1_im[k]  <= n1_im[k];
                s2_re[k]  <= n2_re[k];
                s2_im[k]  <= n2_im[k];
                out_re[k] <= n3_re[k];
                out_im[k] <= n3_im[k];
            end
        end
    end

endmodule

// File: tb/tb_fft8_stream.sv
// Scoreboard bench for fft8_stream: directed frames with hand-computed bins,
// a decoupled output monitor, stall and mid-flight reset scenarios.
module tb_fft8_stream;

    typedef struct packed {
        logic [7:0][15:0] re;
        logic [7:0][15:0] im;
        logic [3:0]       tag;
        logic             ovf;
        logic             lat;
        logic [31:0]      acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [15:0] in_re [0:7];
    logic signed [15:0] in_im [0:7];
    logic in_inv = 1'b0;
    logic in_scale = 1'b0;
    logic [3:0] in_tag = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [15:0] out_re [0:7];
    logic signed [15:0] out_im [0:7];
    logic [3:0] out_tag;
    logic out_ovf;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    exp_t q[$];
    logic [255:0] snap;
    logic [3:0] snap_tag;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft8_stream #(.WIDTH(16), .TW_WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im),
        .in_inv(in_inv), .in_scale(in_scale), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im),
        .out_tag(out_tag), .out_ovf(out_ovf)
    );

    function automatic logic [7:0][15:0] v8(input int a0, a1, a2, a3,
                                            input int a4, a5, a6, a7);
        logic [7:0][15:0] r;
        r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
        r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
        return r;
    endfunction

    function automatic exp_t mk(input logic [7:0][15:0] re, im,
                                input logic [3:0] tag, input logic ovf, lat);
        exp_t e;
        e.re = re; e.im = im; e.tag = tag; e.ovf = ovf; e.lat = lat; e.acc = '0;
        return e;
    endfunction

    function automatic logic [255:0] outs();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*16 +: 16]       = out_re[i];
            r[128 + i*16 +: 16] = out_im[i];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0][15:0] xr, xi, input logic inv, sc,
                        input logic [3:0] tag, input exp_t e, input bit push);
        int w;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            in_re[i] = xr[i];
            in_im[i] = xi[i];
        end
        in_inv = inv; in_scale = sc; in_tag = tag; in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk); #1; w++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: tag %0d never accepted", tag);
        end else begin
            e.acc = cyc;
            if (push) q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 100) begin
            @(negedge clk); w++;
        end
        if (q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d frames outstanding, required 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame: got tag %0d, required no frame", out_tag);
                end else begin
                    e = q.pop_front();
                    check("data", outs(), {e.im, e.re});
                    check("tag", 256'(out_tag), 256'(e.tag));
                    check("ovf", 256'(out_ovf), 256'(e.ovf));
                    if (e.lat) check("latency", 256'(cyc - int'(e.acc)), 256'(3));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0][15:0] z8, imp, x1;
        int seen;
        z8  = v8(0, 0, 0, 0, 0, 0, 0, 0);
        imp = v8(1000, 0, 0, 0, 0, 0, 0, 0);
        x1  = v8(0, 1000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            in_re[i] = '0;
            in_im[i] = '0;
        end

        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_data", outs(), 256'(0));
        check("rst_side", 256'({out_tag, out_ovf}), 256'(0));
        @(negedge clk) rst = 1'b0;

        send(imp, z8, 0, 0, 4'd1,
             mk(v8(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000), z8, 4'd1, 0, 1), 1);
        drain();

        send(v8(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000), z8, 0, 1, 4'd2,
             mk(imp, z8, 4'd2, 0, 1), 1);
        drain();

        send(x1, z8, 0, 0, 4'd3,
             mk(v8(1000, 707, 0, -707, -1000, -707, 0, 707),
                v8(0, -707, -1000, -707, 0, 707, 1000, 707), 4'd3, 0, 1), 1);
        send(x1, z8, 1, 0, 4'd4,
             mk(v8(1000, 707, 0, -707, -1000, -707, 0, 707),
                v8(0, 707, 1000, 707, 0, -707, -1000, -707), 4'd4, 0, 1), 1);
        drain();

        send(v8(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767), z8, 0, 0, 4'd5,
             mk(v8(32767, 0, 0, 0, 0, 0, 0, 0), z8, 4'd5, 1, 1), 1);
        send(v8(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767), z8, 0, 1, 4'd6,
             mk(v8(32767, 0, 0, 0, 0, 0, 0, 0), z8, 4'd6, 0, 1), 1);
        drain();

        fork
            begin
                for (int i = 1; i <= 5; i++)
                    send(v8(100 * i, 0, 0, 0, 0, 0, 0, 0), z8, 0, 0, 4'(i),
                         mk(v8(100 * i, 100 * i, 100 * i, 100 * i,
                               100 * i, 100 * i, 100 * i, 100 * i),
                            z8, 4'(i), 0, 0), 1);
            end
            begin
                int w = 0;
                @(negedge clk);
                while (!out_valid && w < 100) begin
                    @(negedge clk); w++;
                end
                out_ready = 1'b0;
                #1;
                snap = outs();
                snap_tag = out_tag;
                check("stall_in_ready", 256'(in_ready), 256'(0));
                @(negedge clk); #1;
                check("stall_in_ready", 256'(in_ready), 256'(0));
                check("stall_hold", outs(), snap);
                @(negedge clk);
                check("stall_hold_tag", 256'({out_valid, out_tag}), 256'({1'b1, snap_tag}));
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(v8(500, 500, 500, 500, 500, 500, 500, 500), z8, 0, 0, 4'd7, mk(z8, z8, 4'd7, 0, 0), 0);
        send(v8(500, 0, 0, 0, 0, 0, 0, 0), z8, 0, 0, 4'd8, mk(z8, z8, 4'd8, 0, 0), 0);
        seen = 0;
        while (!out_valid && seen < 20) begin
            @(negedge clk); seen++;
        end
        check("pre_rst_valid", 256'(out_valid), 256'(1));
        #3 rst = 1'b1;
        #1;
        check("rst_mid_valid", 256'(out_valid), 256'(0));
        check("rst_mid_data", outs(), 256'(0));
        check("rst_mid_side", 256'({out_tag, out_ovf}), 256'(0));
        check("rst_mid_ready", 256'(in_ready), 256'(1));
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (out_valid) seen++;
        end
        check("no_partial", 256'(seen), 256'(0));
        send(imp, z8, 0, 0, 4'd9,
             mk(v8(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000), z8, 4'd9, 0, 1), 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft8_stream.md
Name: fft8_stream

Overview:
- Fully pipelined 8-point radix-2 decimation-in-frequency FFT/IFFT.
- Accepts one complete 8-sample complex frame per clock and returns the 8 bins in natural order 3 cycles later.
- Generalises the fixed 16-bit FFT8 with parametrised data and twiddle width, per-frame direction and scaling, ready/valid backpressure, tag passthrough and saturation reporting.
- Sits between the frame buffer and the spectral post-processing blocks.

Parameters:
- WIDTH, 16: signed sample width, real and imaginary, inputs and outputs.
- TW_WIDTH, 16: signed twiddle width. C = round(2^(TW_WIDTH-1)/sqrt(2)), e.g. 23170 at 16.
- TAG_W, 4: width of the user tag carried alongside each frame.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input frame valid
- in_ready  out  1  block can accept a frame this cycle
- in_re[0:7]  in  8xWIDTH  time samples, real, signed
- in_im[0:7]  in  8xWIDTH  time samples, imaginary, signed
- in_inv  in  1  1 = inverse transform (conjugate twiddles)
- in_scale  in  1  1 = divide by 2 per stage (overall 1/8)
- in_tag  in  TAG_W  user tag
- out_valid  out  1  output frame valid
- out_ready  in  1  downstream accepts output frame
- out_re[0:7]  out  8xWIDTH  bins X[0..7], real
- out_im[0:7]  out  8xWIDTH  bins X[0..7], imaginary
- out_tag  out  TAG_W  tag of this frame
- out_ovf  out  1  saturation occurred anywhere in this frame

Behaviour:
- Reset (asynchronous): all stage valids, out_valid, out_re, out_im, out_tag and out_ovf go to 0. in_ready = 1 after reset.
- Reset mid-operation discards all frames in flight. No partial output is produced.
- Pipeline structure:
  - Three register stages S1, S2, S3; S3 drives the outputs directly.
  - Global advance enable en = !out_valid || out_ready.
  - in_ready = en (combinational).
  - A frame is accepted when in_valid && in_ready.
  - Latency is exactly 3 cycles from acceptance to out_valid when not stalled.
  - Throughput is 1 frame/clock. Bubbles are not collapsed.
- Stall: when en = 0, every stage register, valid, tag and ovf bit holds its value. Output data is stable while out_valid && !out_ready.
- Sideband: in_inv, in_scale and in_tag travel with their frame. ovf bits are OR-accumulated through the stages.
- Transform definitions:
  - Forward: X[k] = sum x[n]·e^(-j2πnk/8).
  - Inverse: uses e^(+j2πnk/8).
  - No 1/N factor is applied unless in_scale = 1.
- S1 (distance-4 butterflies), n = 0..3:
  - s = x[n] + x[n+4] and d = x[n] − x[n+4], both at WIDTH+1 bits.
  - s goes to slot n; d·W8^n goes to slot n+4.
  - W8^0 = 1.
  - W8^2 = −j (forward) / +j (inverse): implemented as swap/negate, no multiply.
  - W8^1 = C−jC forward, C+jC inverse. W8^3 = −C−jC forward, −C+jC inverse.
  - Multiply result is full precision, then rounded: (p + 2^(TW_WIDTH-2)) >>> (TW_WIDTH-1).
- S2 (distance-2 butterflies within each half): twiddle W4^0 = 1 and W4^1 = −j (forward) / +j (inverse), via swap/negate.
- S3 (distance-1 butterflies, no twiddle). The bit-reversed result is reordered so that out[k] = X[k].
- Per-stage post-processing, applied to every real and imaginary result:
  - If scale: v = (v + 1) >>> 1.
  - Then saturate to [−2^(WIDTH-1), 2^(WIDTH-1)−1] and set ovf if clipped.
  - With scale = 1, only the S1 twiddle products can clip.
- Negation of −2^(WIDTH-1) in swap/negate paths is done at WIDTH+1 bits and then saturated. It never wraps.
- Back-to-back frames with differing in_inv/in_scale are each processed with their own mode.

Test Plan:
- Impulse in_re[0]=1000, others 0, fwd, scale=0 -> all out_re=1000, out_im=0, ovf=0, out_valid exactly 3 cycles after acceptance.
- DC: all in_re=1000, scale=1 -> out_re[0]=1000, all other bins 0, ovf=0.
- in_re[1]=1000, fwd, scale=0 -> X[1]=707−j707, X[2]=0−j1000, X[3]=−707−j707 (±1 LSB). Same frame with inv=1 -> conjugates: X[1]=707+j707, X[2]=0+j1000, X[3]=−707+j707.
- All in_re=32767, scale=0 -> out_re[0]=32767, ovf=1. Next frame, same data with scale=1 -> out_re[0]=32767, ovf=0 (per-frame flag, no stickiness).
- 5 back-to-back frames, tags 1..5, with out_ready held low for 2 cycles while out_valid=1 -> in_ready=0 during the stall, outputs held stable, all 5 frames delivered in order with correct tags and no loss or duplication.
- Assert rst with 2 frames in flight -> out_valid=0 immediately and all outputs 0. After release, a new impulse frame produces a correct result 3 cycles after acceptance.
